// File: rtl/machine_trace_buffer.sv
// machine_trace_buffer: records every change of an upstream state machine's
// {F,S} outputs into a small first-word-fall-through FIFO, counts rising
// edges of F, and flags dropped entries with a sticky overflow bit.
// Optional feature macro: TRACE_TIMESTAMP_EN widens each entry to
// {timestamp[7:0], F, S} using a free-running 8-bit cycle counter.
module machine_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        F,
  input  logic [2:0]  S,
  input  logic        rd_en,
`ifdef TRACE_TIMESTAMP_EN
  output logic [11:0] rd_data,
`else
  output logic [3:0]  rd_data,
`endif
  output logic        empty,
  output logic        full,
  output logic [4:0]  count,
  output logic        overflow,
  output logic [7:0]  f_count
);

  localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
  localparam int         DW      = 12;
`else
  localparam int         DW      = 4;
`endif

  logic [3:0]       prev;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [DW-1:0]    mem [DEPTH];
  logic [DW-1:0]    entry;
  logic             capture;
  logic             push;
  logic             pop;

`ifdef TRACE_TIMESTAMP_EN
  logic [7:0] ts;

  // Free-running cycle counter; wraps naturally from 255 to 0.
  always_ff @(posedge CLK) begin
    if (RESET) ts <= 8'd0;
    else       ts <= ts + 8'd1;
  end

  assign entry = {ts, F, S};
`else
  assign entry = {F, S};
`endif

  assign capture = ({F, S} != prev);
  assign empty   = (count == 5'd0);
  assign full    = (count == DEPTH_C);
  assign pop     = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push    = capture && (!full || rd_en);

  // Control state: previous inputs, pointers, occupancy and status flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev     <= 4'b0000;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
      f_count  <= 8'd0;
    end else begin
      prev <= {F, S};
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (capture && !push) overflow <= 1'b1;
      if (F && !prev[3] && (f_count != 8'hFF)) f_count <= f_count + 8'd1;
    end
  end

  // Entry storage written at the tail on each accepted capture.
  // NOTE: the storage array is deliberately not reset; count/empty gate
  // every read, so stale contents are never observable.
  always_ff @(posedge CLK) begin
    if (!RESET && push) mem[wr_ptr] <= entry;
  end

  // Fall-through read port: head entry when non-empty, zeros otherwise.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    rd_data = '0;
    if (!empty) rd_data = mem[rd_ptr];
  end

endmodule

// File: tb/tb_machine_trace_buffer.sv
// Self-checking bench for machine_trace_buffer: directed scenarios followed
// by randomized traffic, all compared against a queue-based reference model.
// Define TRACE_TIMESTAMP_EN to exercise the timestamp build as well.
module tb_machine_trace_buffer;

  localparam int DEPTH = 8;
`ifdef TRACE_TIMESTAMP_EN
  localparam int DW = 12;
`else
  localparam int DW = 4;
`endif

  logic          CLK = 1'b0;
  logic          RESET;
  logic          F;
  logic [2:0]    S;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [4:0]    count;
  logic          overflow;
  logic [7:0]    f_count;

  machine_trace_buffer #(.DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .F        (F),
    .S        (S),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .f_count  (f_count)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [3:0]    m_prev;
  int            m_fc;
  bit            m_ovf;
  int            m_ts;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    check({tag, ".count"},    32'(count),    32'(q.size()));
    check({tag, ".empty"},    32'(empty),    32'(q.size() == 0));
    check({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".f_count"},  32'(f_count),  32'(m_fc));
    check({tag, ".rd_data"},  32'(rd_data),  32'(head));
  endtask

  function automatic void model_clear();
    q.delete();
    m_prev = 4'b0000;
    m_fc   = 0;
    m_ovf  = 1'b0;
    m_ts   = 0;
  endfunction

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic f, input logic [2:0] s, input logic rd, input string tag);
    logic [3:0]    fs;
    logic [DW-1:0] ent;
    bit            cap, do_pop, do_push;
    logic [7:0]    ts8;
    F = f; S = s; rd_en = rd;
    fs      = {f, s};
    ts8     = m_ts[7:0];
    cap     = (fs != m_prev);
    do_pop  = rd && (q.size() > 0);
    do_push = cap && ((q.size() < DEPTH) || rd);
`ifdef TRACE_TIMESTAMP_EN
    ent = {ts8, fs};
`else
    ent = fs;
`endif
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(ent);
    if (cap && !do_push) m_ovf = 1'b1;
    if (f && !m_prev[3] && m_fc < 255) m_fc++;
    m_prev = fs;
    m_ts   = (m_ts + 1) % 256;
    @(posedge CLK); #1;
    check_all(tag);
  endtask

  task automatic do_reset(input logic f, input logic [2:0] s, input logic rd, input string tag);
    RESET = 1'b1; F = f; S = s; rd_en = rd;
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_clear();
    check_all(tag);
  endtask

  initial begin
    logic [2:0] seq9 [9];
    logic       rf;
    logic [2:0] rs;
    RESET = 1'b1; F = 1'b0; S = 3'd0; rd_en = 1'b0;
    model_clear();

    // Reset then idle at 0000: no captures
    do_reset(1'b0, 3'd0, 1'b0, "reset");
    for (int i = 0; i < 5; i++) step(1'b0, 3'd0, 1'b0, "idle");

    // Three captures, then pop in order
    step(1'b0, 3'd1, 1'b0, "cap1");
    step(1'b0, 3'd2, 1'b0, "cap2");
    step(1'b0, 3'd3, 1'b0, "cap3");
    check("three.count", 32'(count), 32'd3);
    check("three.head",  32'(rd_data[3:0]), 32'h1);
    step(1'b0, 3'd3, 1'b1, "pop1");
    check("three.head2", 32'(rd_data[3:0]), 32'h2);
    step(1'b0, 3'd3, 1'b1, "pop2");
    check("three.head3", 32'(rd_data[3:0]), 32'h3);
    step(1'b0, 3'd3, 1'b1, "pop3");
    check("three.empty", 32'(empty), 32'd1);
    step(1'b0, 3'd3, 1'b1, "pop_empty");

    // Nine changes with no reads: full after 8, overflow after 9
    seq9 = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    for (int i = 0; i < 9; i++) begin
      step(1'b0, seq9[i], 1'b0, "fill");
      if (i == 7) begin
        check("fill.full8", 32'(full), 32'd1);
        check("fill.ovf8",  32'(overflow), 32'd0);
      end
    end
    check("fill.ovf9", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("fill.drain", 32'(rd_data[3:0]), 32'(seq9[i]));
      step(1'b0, 3'd4, 1'b1, "drain");
    end

    // Full FIFO with simultaneous change and pop: no overflow, new tail
    do_reset(1'b1, 3'd5, 1'b1, "reset_mid");
    for (int i = 0; i < 8; i++) step(1'b0, 3'(i + 1), 1'b0, "fill2");
    step(1'b1, 3'd7, 1'b1, "push_pop_full");
    check("ppf.count", 32'(count), 32'd8);
    check("ppf.ovf",   32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 3'd7, 1'b1, "drain2");
    check("ppf.empty", 32'(empty), 32'd1);

    // f_count saturation, then reset clears everything
    do_reset(1'b0, 3'd0, 1'b0, "reset_fc");
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 3'd0, 1'b0, "fpulse_hi");
      step(1'b0, 3'd0, 1'b0, "fpulse_lo");
    end
    check("fc.sat", 32'(f_count), 32'd255);
    do_reset(1'b1, 3'd2, 1'b1, "reset_after_sat");
    check("fc.cleared",  32'(f_count),  32'd0);
    check("fc.empty",    32'(empty),    32'd1);
    check("fc.overflow", 32'(overflow), 32'd0);

`ifdef TRACE_TIMESTAMP_EN
    // Captures at cycles 3 and 10 after reset carry those timestamps
    do_reset(1'b0, 3'd0, 1'b0, "reset_ts");
    for (int c = 0; c < 11; c++) begin
      if (c < 3)       step(1'b0, 3'd0, 1'b0, "ts_idle");
      else if (c < 10) step(1'b0, 3'd1, 1'b0, "ts_hold1");
      else             step(1'b0, 3'd2, 1'b0, "ts_hold2");
    end
    check("ts.first", 32'(rd_data[11:4]), 32'd3);
    step(1'b0, 3'd2, 1'b1, "ts_pop");
    check("ts.second", 32'(rd_data[11:4]), 32'd10);
`endif

    // Randomized traffic with occasional mid-operation resets
    for (int i = 0; i < 600; i++) begin
      rf = (($urandom_range(0, 3) == 0)) ? ~m_prev[3] : m_prev[3];
      rs = ($urandom_range(0, 1) == 0) ? m_prev[2:0] : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 79) == 0)
        do_reset(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rand_reset");
      else
        step(rf, rs, ($urandom_range(0, 9) < 3), "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
